// File: rtl/factorial_pkg.sv
// Shared types and constants for the factorial controller slice.
package factorial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_CHECK,
    ST_MUL,
    ST_WAIT,
    ST_UPDATE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int MAX_N_DEFAULT = 12;

  localparam logic SEL_INIT = 1'b0;
  localparam logic SEL_FB   = 1'b1;

endpackage

// File: rtl/fact_watchdog.sv
// Multiplier watchdog: clear/enable counter whose terminal-count flag marks the
// last permitted WAIT cycle.
module fact_watchdog #(
  parameter int MUL_TIMEOUT = 15
) (
  input  logic clk_,
  input  logic rst_n_,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(MUL_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MUL_TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk_ or negedge rst_n_) begin
    if (!rst_n_) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Flag fires on the enabled cycle whose increment would reach MUL_TIMEOUT.
  assign tc = en && (count_reg == LAST_CNT);

endmodule

// File: rtl/factorial_ctrl.sv
// Moore control FSM sequencing the factorial datapath: load, compare, multiply,
// feedback update, with a multiplier watchdog and range check on n.
module factorial_ctrl
  import factorial_pkg::*;
#(
  parameter int N_W         = 4,
  parameter int MAX_N       = MAX_N_DEFAULT,
  parameter int MUL_TIMEOUT = 15
) (
  input  logic           clk_,
  input  logic           rst_n_,
  input  logic           go_,
  input  logic [N_W-1:0] n_,
  input  logic           cnt_le1_,
  input  logic           mul_done_,
  input  logic           ovf_,
  output logic           sel_,
  output logic           ld_cnt_,
  output logic           ld_prod_,
  output logic           mul_start_,
  output logic [N_W-1:0] n_lat_,
  output logic           busy_,
  output logic           done_,
  output logic           err_
);

  localparam logic [N_W:0] MAX_N_W = (N_W + 1)'(MAX_N);

  state_t state_reg;
  logic   wd_clr;
  logic   wd_en;
  logic   wd_tc;

  // A returning mul_done_ suppresses the increment, so it wins over expiry.
  assign wd_clr = (state_reg == ST_MUL);
  assign wd_en  = (state_reg == ST_WAIT) && !mul_done_;

  fact_watchdog #(
    .MUL_TIMEOUT(MUL_TIMEOUT)
  ) u_watchdog (
    .clk_  (clk_),
    .rst_n_(rst_n_),
    .clr   (wd_clr),
    .en    (wd_en),
    .tc    (wd_tc)
  );

  always_ff @(posedge clk_ or negedge rst_n_) begin
    if (!rst_n_) begin
      state_reg <= ST_IDLE;
      n_lat_    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (go_) begin
            n_lat_    <= n_;
            state_reg <= ({1'b0, n_} > MAX_N_W) ? ST_ERR : ST_INIT;
          end
        end
        ST_INIT:   state_reg <= ST_CHECK;
        ST_CHECK:  state_reg <= cnt_le1_ ? ST_DONE : ST_MUL;
        ST_MUL:    state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (mul_done_) begin
            state_reg <= ovf_ ? ST_ERR : ST_UPDATE;
          end else if (wd_tc) begin
            state_reg <= ST_ERR;
          end
        end
        ST_UPDATE: state_reg <= ST_CHECK;
        ST_DONE:   state_reg <= ST_IDLE;
        ST_ERR:    state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_       = SEL_INIT;
    ld_cnt_    = 1'b0;
    ld_prod_   = 1'b0;
    mul_start_ = 1'b0;
    busy_      = (state_reg != ST_IDLE);
    done_      = 1'b0;
    err_       = 1'b0;
    case (state_reg)
      ST_INIT: begin
        ld_cnt_  = 1'b1;
        ld_prod_ = 1'b1;
      end
      ST_MUL:    mul_start_ = 1'b1;
      ST_UPDATE: begin
        sel_     = SEL_FB;
        ld_cnt_  = 1'b1;
        ld_prod_ = 1'b1;
      end
      ST_DONE:   done_ = 1'b1;
      ST_ERR: begin
        done_ = 1'b1;
        err_  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_factorial_ctrl.sv
// Directed bench: factorial_ctrl driving a behavioural datapath and a multiplier
// model with programmable latency, hang and forced overflow.
module tb_factorial_ctrl;
  import factorial_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [3:0]  n_in = 4'd0;
  logic        cnt_le1, mul_done, ovf;
  logic        sel, ld_cnt, ld_prod, mul_start, busy, done, err;
  logic [3:0]  n_lat;

  int n_cmp = 0;
  int n_mis = 0;

  int mul_lat = 2;
  bit mul_hang = 1'b0;
  bit force_ovf = 1'b0;

  logic [3:0]  cnt_reg;
  logic [31:0] prod_reg, res_reg;
  logic        ovf_pend, pend;
  int          timer;
  logic [63:0] full_prod;

  always #5 clk = ~clk;

  factorial_ctrl dut (
    .clk_      (clk),
    .rst_n_    (rst_n),
    .go_       (go),
    .n_        (n_in),
    .cnt_le1_  (cnt_le1),
    .mul_done_ (mul_done),
    .ovf_      (ovf),
    .sel_      (sel),
    .ld_cnt_   (ld_cnt),
    .ld_prod_  (ld_prod),
    .mul_start_(mul_start),
    .n_lat_    (n_lat),
    .busy_     (busy),
    .done_     (done),
    .err_      (err)
  );

  assign cnt_le1   = (cnt_reg <= 4'd1);
  assign full_prod = {32'd0, prod_reg} * {60'd0, cnt_reg};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= 4'd0;
      prod_reg <= 32'd0;
    end else begin
      if (ld_cnt)  cnt_reg  <= (sel == SEL_FB) ? cnt_reg - 4'd1 : n_lat;
      if (ld_prod) prod_reg <= (sel == SEL_FB) ? res_reg : 32'd1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_done <= 1'b0;
      ovf      <= 1'b0;
      pend     <= 1'b0;
      ovf_pend <= 1'b0;
      timer    <= 0;
      res_reg  <= 32'd0;
    end else begin
      mul_done <= 1'b0;
      ovf      <= 1'b0;
      if (mul_start && !mul_hang) begin
        res_reg  <= full_prod[31:0];
        ovf_pend <= force_ovf || (|full_prod[63:32]);
        if (mul_lat <= 1) begin
          mul_done <= 1'b1;
          ovf      <= force_ovf || (|full_prod[63:32]);
        end else begin
          timer <= mul_lat - 1;
          pend  <= 1'b1;
        end
      end else if (pend) begin
        timer <= timer - 1;
        if (timer == 1) begin
          pend     <= 1'b0;
          mul_done <= 1'b1;
          ovf      <= ovf_pend;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // go_ sampled in cycle 0; outputs observed mid-cycle k for k >= 1.
  task automatic run_op(input logic [3:0] n, input int lat, input bit hang, input bit ovf_f,
                        input int pulse_at, output int done_cyc, output bit err_seen,
                        output int starts, output int loads);
    @(negedge clk);
    mul_lat   = lat;
    mul_hang  = hang;
    force_ovf = ovf_f;
    n_in      = n;
    go        = 1'b1;
    done_cyc  = -1;
    err_seen  = 1'b0;
    starts    = 0;
    loads     = 0;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      go = (k == pulse_at);
      if (k == pulse_at) n_in = 4'd13;
      if (mul_start) starts++;
      if (ld_cnt || ld_prod) loads++;
      if (done) begin
        done_cyc = k;
        err_seen = err;
        break;
      end
    end
    go = 1'b0;
    $display("op n=%0d L=%0d hang=%0d ovf=%0d: done@%0d err=%0d starts=%0d prod=%0d",
             n, lat, hang, ovf_f, done_cyc, err_seen, starts, prod_reg);
  endtask

  int  dc, st, ld, cnt_done, first_d, second_d, idle_k;
  bit  es;

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'({done, err, mul_start, ld_cnt, ld_prod, sel}), 64'd0);
    check_val("rst_nlat", 64'(n_lat), 64'd0);
    rst_n = 1'b1;

    run_op(4'd0, 2, 1'b0, 1'b0, -1, dc, es, st, ld);
    check_val("n0_cycle", 64'(dc), 64'd3);
    check_val("n0_err", 64'(es), 64'd0);
    check_val("n0_starts", 64'(st), 64'd0);
    check_val("n0_prod", 64'(prod_reg), 64'd1);

    run_op(4'd1, 2, 1'b0, 1'b0, -1, dc, es, st, ld);
    check_val("n1_cycle", 64'(dc), 64'd3);
    check_val("n1_err", 64'(es), 64'd0);
    check_val("n1_starts", 64'(st), 64'd0);
    check_val("n1_prod", 64'(prod_reg), 64'd1);

    run_op(4'd5, 2, 1'b0, 1'b0, -1, dc, es, st, ld);
    check_val("n5_cycle", 64'(dc), 64'd23);
    check_val("n5_err", 64'(es), 64'd0);
    check_val("n5_starts", 64'(st), 64'd4);
    check_val("n5_prod", 64'(prod_reg), 64'd120);

    run_op(4'd13, 2, 1'b0, 1'b0, -1, dc, es, st, ld);
    check_val("n13_cycle", 64'(dc), 64'd1);
    check_val("n13_err", 64'(es), 64'd1);
    check_val("n13_loads", 64'(ld), 64'd0);
    check_val("n13_nlat", 64'(n_lat), 64'd13);

    run_op(4'd12, 2, 1'b0, 1'b0, -1, dc, es, st, ld);
    check_val("n12_cycle", 64'(dc), 64'd58);
    check_val("n12_err", 64'(es), 64'd0);
    check_val("n12_prod", 64'(prod_reg), 64'd479001600);

    run_op(4'd6, 2, 1'b1, 1'b0, -1, dc, es, st, ld);
    check_val("hang_cycle", 64'(dc), 64'd19);
    check_val("hang_err", 64'(es), 64'd1);

    run_op(4'd6, 15, 1'b0, 1'b0, -1, dc, es, st, ld);
    check_val("edge_cycle", 64'(dc), 64'd93);
    check_val("edge_err", 64'(es), 64'd0);
    check_val("edge_prod", 64'(prod_reg), 64'd720);

    run_op(4'd3, 2, 1'b0, 1'b1, -1, dc, es, st, ld);
    check_val("ovf_cycle", 64'(dc), 64'd6);
    check_val("ovf_err", 64'(es), 64'd1);

    run_op(4'd3, 2, 1'b0, 1'b0, 5, dc, es, st, ld);
    check_val("ign_cycle", 64'(dc), 64'd13);
    check_val("ign_err", 64'(es), 64'd0);
    check_val("ign_nlat", 64'(n_lat), 64'd3);
    check_val("ign_prod", 64'(prod_reg), 64'd6);
    cnt_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) cnt_done++;
    end
    check_val("ign_no_restart", 64'(cnt_done), 64'd0);

    // go_ held high: second op starts on the single IDLE cycle after DONE.
    @(negedge clk);
    mul_lat = 2; mul_hang = 1'b0; force_ovf = 1'b0; n_in = 4'd2; go = 1'b1;
    first_d = -1; second_d = -1; idle_k = -1;
    for (int k = 1; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        if (first_d < 0) first_d = k;
        else if (second_d < 0) second_d = k;
      end
      if (!busy && idle_k < 0) idle_k = k;
      if (second_d >= 0) break;
    end
    go = 1'b0;
    $display("op held-go n=2 L=2: done@%0d,%0d idle@%0d prod=%0d", first_d, second_d, idle_k, prod_reg);
    check_val("held_first", 64'(first_d), 64'd8);
    check_val("held_idle", 64'(idle_k), 64'd9);
    check_val("held_second", 64'(second_d), 64'd17);

    // Reset asserted mid-WAIT.
    @(negedge clk);
    mul_lat = 10; n_in = 4'd5; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    check_val("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_outs", 64'({done, err, mul_start, ld_cnt, ld_prod, sel}), 64'd0);
    check_val("mid_rst_nlat", 64'(n_lat), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) cnt_done++;
    end
    $display("op reset mid-WAIT: activity after release=%0d", cnt_done);
    check_val("mid_no_done", 64'(cnt_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
